// File: rtl/npc_unit.sv
// Fetch PC register and next-PC selection (sequential, branch, jump, jr, exception, eret).
// A redirect seen during a stall is parked in a one-entry buffer and applied on the first unstalled edge.
module npc_unit #(
  parameter int              WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(32'h0000_3000),
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(32'h0000_4180)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_pc,
  input  logic [WIDTH-1:0] br_offset,
  input  logic             j_en,
  input  logic [25:0]      j_index,
  input  logic             jr_en,
  input  logic [WIDTH-1:0] jr_addr,
  input  logic             exc,
  input  logic             eret,
  input  logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             pend,
  output logic             misalign
);

  typedef enum logic {IDLE, PEND} state_t;

  localparam logic [WIDTH-1:0] FOUR = WIDTH'(4);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_pc, w_pc_nxt;
  logic [WIDTH-1:0] r_buf, w_buf_nxt;
  logic             r_buf_exc, w_buf_exc_nxt;
  logic             r_misalign;

  logic [WIDTH-1:0] w_br_plus4;
  logic [WIDTH-1:0] w_br_tgt;
  logic [WIDTH-1:0] w_j_tgt;
  logic             w_new_req;
  logic             w_new_is_exc;
  logic [WIDTH-1:0] w_new_tgt;
  logic             w_take_new;

  assign w_br_plus4 = br_pc + FOUR;
  assign w_br_tgt   = w_br_plus4 + {br_offset[WIDTH-3:0], 2'b00};
  assign w_j_tgt    = {w_br_plus4[WIDTH-1:28], j_index, 2'b00};

  always_comb begin
    w_new_req    = 1'b1;
    w_new_is_exc = 1'b0;
    w_new_tgt    = w_br_tgt;
    if (exc) begin
      w_new_is_exc = 1'b1;
      w_new_tgt    = EXC_VECTOR;
    end else if (eret) begin
      w_new_tgt = epc;
    end else if (jr_en) begin
      w_new_tgt = jr_addr;
    end else if (j_en) begin
      w_new_tgt = w_j_tgt;
    end else if (!br_taken) begin
      w_new_req = 1'b0;
    end
  end

  // A buffered exception must never be displaced by an ordinary redirect.
  assign w_take_new = w_new_req && (w_new_is_exc || !r_buf_exc);

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_buf_nxt     = r_buf;
    w_buf_exc_nxt = r_buf_exc;
    case (r_state)
      IDLE: begin
        if (!stall) begin
          w_pc_nxt = w_new_req ? w_new_tgt : pc_plus4;
        end else if (w_new_req) begin
          w_buf_nxt     = w_new_tgt;
          w_buf_exc_nxt = w_new_is_exc;
          w_state_nxt   = PEND;
        end
      end
      PEND: begin
        if (stall) begin
          if (w_take_new) begin
            w_buf_nxt     = w_new_tgt;
            w_buf_exc_nxt = w_new_is_exc;
          end
        end else begin
          w_pc_nxt    = w_take_new ? w_new_tgt : r_buf;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_buf      <= '0;
      r_buf_exc  <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_buf      <= w_buf_nxt;
      r_buf_exc  <= w_buf_exc_nxt;
      r_misalign <= (w_pc_nxt[1:0] != 2'b00);
    end
  end

  assign pc       = r_pc;
  assign pc_plus4 = r_pc + FOUR;
  assign pend     = (r_state == PEND);
  assign misalign = r_misalign;

endmodule

// File: tb/tb_npc_unit.sv
// Directed bench for npc_unit: reset, redirect sources and priority, stall buffering, misalign and wrap.
module tb_npc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_pc;
  logic [31:0] br_offset;
  logic        j_en;
  logic [25:0] j_index;
  logic        jr_en;
  logic [31:0] jr_addr;
  logic        exc;
  logic        eret;
  logic [31:0] epc;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pend;
  logic        misalign;

  int n_total = 0;
  int n_bad   = 0;

  npc_unit dut (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .br_taken (br_taken),
    .br_pc    (br_pc),
    .br_offset(br_offset),
    .j_en     (j_en),
    .j_index  (j_index),
    .jr_en    (jr_en),
    .jr_addr  (jr_addr),
    .exc      (exc),
    .eret     (eret),
    .epc      (epc),
    .pc       (pc),
    .pc_plus4 (pc_plus4),
    .pend     (pend),
    .misalign (misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [31:0] e_pc, input logic e_pend);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".pend"}, {31'b0, pend}, {31'b0, e_pend});
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; br_taken = 1'b0; br_pc = '0; br_offset = '0;
    j_en = 1'b0; j_index = '0; jr_en = 1'b0; jr_addr = '0;
    exc = 1'b0; eret = 1'b0; epc = '0;

    #12;
    chk_state("rst", 32'h0000_3000, 1'b0);
    chk("rst.mis", {31'b0, misalign}, 32'd0);
    chk("rst.p4", pc_plus4, 32'h0000_3004);
    reset = 1'b0;

    tick; chk_state("seq1", 32'h0000_3004, 1'b0);
    tick; chk_state("seq2", 32'h0000_3008, 1'b0);
    tick; chk_state("seq3", 32'h0000_300C, 1'b0);

    br_taken = 1'b1; br_pc = 32'h0000_3010; br_offset = 32'hFFFF_FFFE;
    tick; chk("br_neg", pc, 32'h0000_300C);
    br_offset = 32'd3;
    tick; chk("br_pos", pc, 32'h0000_3020);

    exc = 1'b1; jr_en = 1'b1; jr_addr = 32'h0000_5000;
    tick; chk("prio_exc", pc, 32'h0000_4180);
    exc = 1'b0; jr_en = 1'b0; br_taken = 1'b0;
    tick; chk("seq_after", pc, 32'h0000_4184);

    stall = 1'b1; j_en = 1'b1; j_index = 26'h000_0C40; br_pc = 32'h0000_3000;
    tick; chk_state("stl1", 32'h0000_4184, 1'b1);
    j_en = 1'b0;
    tick; chk_state("stl2", 32'h0000_4184, 1'b1);
    tick; chk_state("stl3", 32'h0000_4184, 1'b1);
    stall = 1'b0;
    tick; chk_state("j_rel", 32'h0000_3100, 1'b0);

    stall = 1'b1; exc = 1'b1;
    tick; chk_state("bexc1", 32'h0000_3100, 1'b1);
    exc = 1'b0; jr_en = 1'b1; jr_addr = 32'h0000_5000;
    tick; chk_state("bexc2", 32'h0000_3100, 1'b1);
    stall = 1'b0;
    tick; chk_state("bexc_rel", 32'h0000_4180, 1'b0);

    jr_addr = 32'h0000_3002;
    tick; chk("mis.pc", pc, 32'h0000_3002);
    chk("mis.flag", {31'b0, misalign}, 32'd1);

    jr_addr = 32'hFFFF_FFFC;
    tick; chk("wrap.pc", pc, 32'hFFFF_FFFC);
    chk("wrap.p4", pc_plus4, 32'h0000_0000);
    chk("wrap.mis", {31'b0, misalign}, 32'd0);
    jr_en = 1'b0;
    tick; chk("wrap.next", pc, 32'h0000_0000);

    stall = 1'b1; jr_en = 1'b1; jr_addr = 32'h0000_5000;
    tick; chk_state("rpend", 32'h0000_0000, 1'b1);
    #2 reset = 1'b1;
    #1 chk_state("rmid", 32'h0000_3000, 1'b0);
    reset = 1'b0; stall = 1'b0; jr_en = 1'b0;
    tick; chk_state("rafter", 32'h0000_3004, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
